teller_dispatcher: RTL and testbench



---
 rtl/teller_if.sv | 29 ++
 rtl/teller_dispatcher.sv | 164 ++++++++++++++++
 tb/tb_teller_dispatcher.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/teller_if.sv
// Customer handshake and teller status bundle between the queue/display side and
// teller_dispatcher. The master drives customers and shift presence; the slave reports status.
interface teller_if #(
  parameter int SVC_W = 4,
  parameter int CNT_W = 8
);
  logic [2:0]       teller_present;
  logic             cust_valid;
  logic [SVC_W-1:0] cust_svc_len;
  logic             cust_ready;
  logic             dispatch_valid;
  logic [1:0]       dispatch_id;
  logic [2:0]       done_mask;
  logic [2:0]       teller_busy;
  logic [2:0]       num_tellers;
  logic [CNT_W-1:0] total_served;

  modport master (
    output teller_present, cust_valid, cust_svc_len,
    input  cust_ready, dispatch_valid, dispatch_id, done_mask,
           teller_busy, num_tellers, total_served
  );

  modport slave (
    input  teller_present, cust_valid, cust_svc_len,
    output cust_ready, dispatch_valid, dispatch_id, done_mask,
           teller_busy, num_tellers, total_served
  );
endinterface

// File: rtl/teller_dispatcher.sv
// Three-teller service tracker: assigns queue-head customers to idle tellers, times service,
// and reports open/busy/done status. Define TELLER_RR_EN for round-robin grant instead of fixed priority.
//
// state   | meaning
// ST_OFF  | teller not on shift, cannot accept customers
// ST_IDLE | teller open and free, may be granted a customer
// ST_BUSY | serving a customer, timer counts down to 1
module teller_dispatcher #(
  parameter int SVC_W = 4,
  parameter int CNT_W = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  teller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } st_e;

  st_e              state_q [3];
  st_e              state_d [3];
  logic [SVC_W-1:0] timer_q [3];
  logic [SVC_W-1:0] timer_d [3];

  logic [2:0]       idle;
  logic [2:0]       busy;
  logic [2:0]       open;
  logic [2:0]       done_d;
  logic [2:0]       done_q;
  logic             xfer;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [1:0]       grant_start;
  logic [2:0]       cand;
  logic [SVC_W-1:0] svc_eff;
  logic             dv_q;
  logic [1:0]       id_q;
  logic [CNT_W-1:0] total_q;
  logic [1:0]       done_cnt;

`ifdef TELLER_RR_EN
  logic [1:0] rr_ptr_q;

  // Pointer starts at 2 so the first search begins at teller 0.
  assign grant_start = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 2'd2;
    end else if (xfer) begin
      rr_ptr_q <= grant_idx;
    end
  end
`else
  assign grant_start = 2'd0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_OFF;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  // Output decode from registered state only, so cust_ready never depends on cust_valid.
  always_comb begin
    idle   = '0;
    busy   = '0;
    open   = '0;
    done_d = '0;
    for (int i = 0; i < 3; i++) begin
      idle[i]   = (state_q[i] == ST_IDLE);
      busy[i]   = (state_q[i] == ST_BUSY);
      open[i]   = (state_q[i] != ST_OFF);
      done_d[i] = (state_q[i] == ST_BUSY) && (timer_q[i] == SVC_W'(1));
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, grant_start} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!grant_found && idle[cand[1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[1:0];
      end
    end
  end

  assign xfer    = bus.cust_valid & (|idle);
  assign svc_eff = (bus.cust_svc_len == '0) ? SVC_W'(1) : bus.cust_svc_len;

  // Next-state: a granted teller goes BUSY even if its presence drops in the same cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (bus.teller_present[i]) state_d[i] = ST_IDLE;
        end
        ST_IDLE: begin
          if (xfer && (grant_idx == 2'(i))) begin
            state_d[i] = ST_BUSY;
            timer_d[i] = svc_eff;
          end else if (!bus.teller_present[i]) begin
            state_d[i] = ST_OFF;
          end
        end
        ST_BUSY: begin
          if (timer_q[i] == SVC_W'(1)) begin
            state_d[i] = bus.teller_present[i] ? ST_IDLE : ST_OFF;
            timer_d[i] = '0;
          end else begin
            timer_d[i] = timer_q[i] - SVC_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          timer_d[i] = '0;
        end
      endcase
    end
  end

  assign done_cnt = 2'(done_q[0]) + 2'(done_q[1]) + 2'(done_q[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q    <= 1'b0;
      id_q    <= 2'd0;
      done_q  <= '0;
      total_q <= '0;
    end else begin
      dv_q <= xfer;
      if (xfer) id_q <= grant_idx;
      done_q  <= done_d;
      total_q <= total_q + CNT_W'(done_cnt);
    end
  end

  assign bus.cust_ready     = |idle;
  assign bus.dispatch_valid = dv_q;
  assign bus.dispatch_id    = id_q;
  assign bus.done_mask      = done_q;
  assign bus.teller_busy    = busy;
  assign bus.num_tellers    = open;
  assign bus.total_served   = total_q;

endmodule

// File: tb/tb_teller_dispatcher.sv
// Bench for teller_dispatcher: directed vector table, hand sequences for draining,
// wrap and async reset, then random traffic against a cycle-level service model.
module tb_teller_dispatcher;
  localparam int SVC_W = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  teller_if #(.SVC_W(SVC_W), .CNT_W(CNT_W)) bus ();

  teller_dispatcher #(.SVC_W(SVC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: cycles of service left per teller, whether it is on shift, last completions.
  int         m_left [3];
  bit         m_open [3];
  logic [2:0] m_done;
  int         m_served;
  bit         m_dv;
  int         m_id;
  int         m_last;

  typedef struct {
    logic [2:0] pres;
    logic       v;
    logic [3:0] len;
    logic       rdy;
    logic       dv;
    logic [1:0] id;
    logic [2:0] busy;
    logic [2:0] num;
    logic [2:0] done;
    logic [7:0] total;
  } vec_t;

  vec_t tbl [8];
  int   exp_ids [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_left[i] = 0;
      m_open[i] = 1'b0;
    end
    m_done   = '0;
    m_served = 0;
    m_dv     = 1'b0;
    m_id     = 0;
    m_last   = 2;
  endtask

  task automatic model_edge();
    bit ready;
    int g;
    int len;
    logic [2:0] new_done;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) if (m_open[i] && m_left[i] == 0) ready = 1'b1;
    g = -1;
    if (bus.cust_valid && ready) begin
`ifdef TELLER_RR_EN
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_last + 1 + k) % 3;
        if (g < 0 && m_open[idx] && m_left[idx] == 0) g = idx;
      end
`else
      for (int i = 0; i < 3; i++) if (g < 0 && m_open[i] && m_left[i] == 0) g = i;
`endif
    end
    m_served = (m_served + $countones(m_done)) % 256;
    for (int i = 0; i < 3; i++) new_done[i] = (m_left[i] == 1);
    len = int'(bus.cust_svc_len);
    for (int i = 0; i < 3; i++) begin
      if (m_left[i] > 0) begin
        m_left[i]--;
        if (m_left[i] == 0) m_open[i] = bus.teller_present[i];
      end else if (i == g) begin
        m_left[i] = (len == 0) ? 1 : len;
      end else begin
        m_open[i] = bus.teller_present[i];
      end
    end
    m_done = new_done;
    m_dv   = (g >= 0);
    if (g >= 0) begin
      m_id   = g;
      m_last = g;
    end
  endtask

  task automatic compare_model();
    logic [2:0] eb;
    logic [2:0] en;
    logic       er;
    er = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eb[i] = (m_left[i] > 0);
      en[i] = m_open[i];
      if (m_open[i] && m_left[i] == 0) er = 1'b1;
    end
    check("cust_ready",     32'(bus.cust_ready),     32'(er));
    check("dispatch_valid", 32'(bus.dispatch_valid), 32'(m_dv));
    check("dispatch_id",    32'(bus.dispatch_id),    32'(m_id));
    check("teller_busy",    32'(bus.teller_busy),    32'(eb));
    check("num_tellers",    32'(bus.num_tellers),    32'(en));
    check("done_mask",      32'(bus.done_mask),      32'(m_done));
    check("total_served",   32'(bus.total_served),   32'(m_served));
  endtask

  task automatic drive(input logic [2:0] p, input logic v, input logic [3:0] l);
    bus.teller_present = p;
    bus.cust_valid     = v;
    bus.cust_svc_len   = l;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  initial begin
    int guard;
    drive(3'b000, 1'b0, 4'd0);
    model_reset();

    tbl[0] = '{3'b101, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 3'b000, 3'b101, 3'b000, 8'd0};
    tbl[1] = '{3'b101, 1'b1, 4'd3, 1'b1, 1'b1, 2'd0, 3'b001, 3'b101, 3'b000, 8'd0};
    tbl[2] = '{3'b101, 1'b1, 4'd0, 1'b0, 1'b1, 2'd2, 3'b101, 3'b101, 3'b000, 8'd0};
    tbl[3] = '{3'b101, 1'b1, 4'd5, 1'b1, 1'b0, 2'd2, 3'b001, 3'b101, 3'b100, 8'd0};
    tbl[4] = '{3'b101, 1'b0, 4'd0, 1'b1, 1'b0, 2'd2, 3'b000, 3'b101, 3'b001, 8'd1};
    tbl[5] = '{3'b101, 1'b0, 4'd0, 1'b1, 1'b0, 2'd2, 3'b000, 3'b101, 3'b000, 8'd2};
    tbl[6] = '{3'b001, 1'b0, 4'd0, 1'b1, 1'b0, 2'd2, 3'b000, 3'b001, 3'b000, 8'd2};
    tbl[7] = '{3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 2'd2, 3'b000, 3'b000, 3'b000, 8'd2};
`ifdef TELLER_RR_EN
    exp_ids = '{0, 1, 2, 0};
`else
    exp_ids = '{0, 1, 0, 1};
`endif

    #12;
    compare_model();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].pres, tbl[i].v, tbl[i].len);
      step();
      check($sformatf("tbl%0d_ready", i), 32'(bus.cust_ready),     32'(tbl[i].rdy));
      check($sformatf("tbl%0d_dv", i),    32'(bus.dispatch_valid), 32'(tbl[i].dv));
      check($sformatf("tbl%0d_id", i),    32'(bus.dispatch_id),    32'(tbl[i].id));
      check($sformatf("tbl%0d_busy", i),  32'(bus.teller_busy),    32'(tbl[i].busy));
      check($sformatf("tbl%0d_num", i),   32'(bus.num_tellers),    32'(tbl[i].num));
      check($sformatf("tbl%0d_done", i),  32'(bus.done_mask),      32'(tbl[i].done));
      check($sformatf("tbl%0d_total", i), 32'(bus.total_served),   32'(tbl[i].total));
    end

    // Back-to-back single-cycle customers with all three tellers open.
    drive(3'b111, 1'b0, 4'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 1'b1, 4'd1);
      step();
      check($sformatf("seq%0d_dv", i), 32'(bus.dispatch_valid), 32'd1);
      check($sformatf("seq%0d_id", i), 32'(bus.dispatch_id),    32'(exp_ids[i]));
    end
    drive(3'b111, 1'b0, 4'd0);
    repeat (3) step();

    // Teller 1 drains a 6-cycle customer after its presence drops.
    drive(3'b010, 1'b0, 4'd0);
    step();
    drive(3'b010, 1'b1, 4'd6);
    step();
    check("drain_id", 32'(bus.dispatch_id), 32'd1);
    step();
    drive(3'b000, 1'b1, 4'd6);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("drain%0d_num", i),  32'(bus.num_tellers), 32'h2);
      check($sformatf("drain%0d_busy", i), 32'(bus.teller_busy), 32'h2);
    end
    step();
    check("drain_done", 32'(bus.done_mask),      32'h2);
    check("drain_num",  32'(bus.num_tellers),    32'h0);
    check("drain_dv",   32'(bus.dispatch_valid), 32'h0);
    drive(3'b000, 1'b0, 4'd0);
    step();

    // Bring the served count to 255, then finish two customers on the same edge.
    drive(3'b111, 1'b0, 4'd0);
    step();
    guard = 0;
    while (m_served != 255 && guard < 300) begin
      drive(3'b111, 1'b1, 4'd1);
      step();
      drive(3'b111, 1'b0, 4'd0);
      step();
      step();
      guard++;
    end
    check("wrap_preset", 32'(bus.total_served), 32'd255);
    drive(3'b111, 1'b1, 4'd2);
    step();
    drive(3'b111, 1'b1, 4'd1);
    step();
    drive(3'b111, 1'b0, 4'd0);
    step();
    check("wrap_double_done", 32'($countones(bus.done_mask)), 32'd2);
    step();
    check("wrap_total", 32'(bus.total_served), 32'd1);

    // Asynchronous reset in the middle of service.
    drive(3'b111, 1'b1, 4'd9);
    step();
    drive(3'b111, 1'b0, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_model();
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      logic [2:0] p;
      p = bus.teller_present;
      if ($urandom_range(0, 7) == 0) p = 3'($urandom_range(0, 7));
      drive(p, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
